// File: rtl/video_sync_decoder.sv
// Composite sync separator: tracks the sync tip and classifies pulses. Runs a flywheel line lock
// and detects the field, then emits line/frame strobes, x/y coordinates and an active-video flag.
module video_sync_decoder #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned LEAK_W      = 16,
    parameter int unsigned SYNC_MARGIN = 250,
    parameter int unsigned HYST        = 32,
    parameter int unsigned HSYNC_MIN   = 20,
    parameter int unsigned VSYNC_MIN   = 800,
    parameter int unsigned LINE_LEN    = 2343,
    parameter int unsigned LINE_TOL    = 64,
    parameter int unsigned LOCK_LINES  = 8,
    parameter int unsigned MAX_MISS    = 4,
    parameter int unsigned BACK_PORCH  = 175,
    parameter int unsigned ACTIVE_W    = 1920,
    parameter int unsigned V_ACTIVE    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              h_sync_pulse,
    output logic              v_sync_pulse,
    output logic              field,
    output logic              active_video,
    output logic [CNT_W-1:0]  x_coord,
    output logic [CNT_W-1:0]  y_coord,
    output logic              locked,
    output logic [CNT_W-1:0]  line_len
);

    localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);
    localparam int unsigned MISS_W = $clog2(MAX_MISS + 1);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(LINE_LEN - LINE_TOL);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(LINE_LEN + LINE_TOL);
    localparam logic [CNT_W-1:0] HALF_LO = CNT_W'(LINE_LEN / 2 - LINE_TOL);
    localparam logic [CNT_W-1:0] HALF_HI = CNT_W'(LINE_LEN / 2 + LINE_TOL);
    localparam logic [CNT_W-1:0] ACT_LO  = CNT_W'(BACK_PORCH);
    localparam logic [CNT_W-1:0] ACT_HI  = CNT_W'(BACK_PORCH + ACTIVE_W);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   tip_q;
    logic [LEAK_W-1:0]   leak_q;
    logic                sync_lvl_q;
    logic                vflag_q;
    logic                field_n_q;
    logic [CNT_W-1:0]    low_cnt_q;
    logic [CNT_W-1:0]    since_q;
    logic [GOOD_W-1:0]   good_q;
    logic [MISS_W-1:0]   miss_q;

    logic [DATA_W:0]     thr_sum, hi_sum;
    logic [DATA_W-1:0]   thr, hi;
    logic                sync_nxt, sync_exit, hs_edge, broad_edge;
    logic                in_win, in_half, real_start, coast, line_start;
    logic [CNT_W-1:0]    x_nxt;
    logic [GOOD_W-1:0]   good_inc;
    logic [MISS_W-1:0]   miss_inc;

    assign x_coord = since_q;

    always_comb begin
        // Overflow bit of the wide sum selects saturation to all-ones.
        thr_sum    = {1'b0, tip_q} + (DATA_W + 1)'(SYNC_MARGIN);
        thr        = thr_sum[DATA_W] ? '1 : thr_sum[DATA_W-1:0];
        hi_sum     = {1'b0, thr} + (DATA_W + 1)'(HYST);
        hi         = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
        sync_nxt   = sync_lvl_q;
        if (adc_data < thr) begin
            sync_nxt = 1'b1;
        end else if (adc_data >= hi) begin
            sync_nxt = 1'b0;
        end
        sync_exit  = sync_lvl_q && !sync_nxt;
        broad_edge = sync_exit && (low_cnt_q > CNT_W'(VSYNC_MIN));
        hs_edge    = sync_exit && (low_cnt_q > CNT_W'(HSYNC_MIN))
                     && (low_cnt_q <= CNT_W'(VSYNC_MIN));
        in_win     = (since_q >= WIN_LO) && (since_q <= WIN_HI);
        in_half    = (since_q >= HALF_LO) && (since_q <= HALF_HI);
        real_start = (state_q == StSearch) ? hs_edge : (hs_edge && since_q >= WIN_LO);
        coast      = (state_q == StLocked) && !real_start && (since_q >= WIN_HI);
        line_start = real_start || coast;
        x_nxt      = line_start ? '0 : ((since_q == '1) ? since_q : since_q + 1'b1);
        good_inc   = good_q + GOOD_W'(1);
        miss_inc   = miss_q + MISS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSearch;
            tip_q        <= '1;
            leak_q       <= '0;
            sync_lvl_q   <= 1'b0;
            vflag_q      <= 1'b0;
            field_n_q    <= 1'b0;
            low_cnt_q    <= '0;
            since_q      <= '0;
            good_q       <= '0;
            miss_q       <= '0;
            h_sync_pulse <= 1'b0;
            v_sync_pulse <= 1'b0;
            field        <= 1'b0;
            active_video <= 1'b0;
            y_coord      <= '0;
            locked       <= 1'b0;
            line_len     <= '0;
        end else begin
            h_sync_pulse <= 1'b0;
            v_sync_pulse <= 1'b0;
            if (sample_valid) begin
                // Tip follows minima instantly and leaks upward slowly otherwise.
                if (adc_data < tip_q) begin
                    tip_q <= adc_data;
                end else begin
                    leak_q <= leak_q + 1'b1;
                    if (leak_q == '1 && tip_q != '1) begin
                        tip_q <= tip_q + 1'b1;
                    end
                end
                sync_lvl_q <= sync_nxt;
                if (sync_exit) begin
                    low_cnt_q <= '0;
                end else if (sync_nxt && low_cnt_q != '1) begin
                    low_cnt_q <= low_cnt_q + 1'b1;
                end

                unique case (state_q)
                    StSearch: begin
                        if (real_start) begin
                            if (in_win) begin
                                good_q <= good_inc;
                                if (good_inc == GOOD_W'(LOCK_LINES)) begin
                                    state_q <= StLocked;
                                    locked  <= 1'b1;
                                    miss_q  <= '0;
                                end
                            end else begin
                                good_q <= '0;
                            end
                        end
                    end
                    StLocked: begin
                        if (real_start) begin
                            miss_q <= '0;
                        end else if (coast && !vflag_q) begin
                            // Serrated vsync legitimately hides hsyncs; only count misses outside it.
                            if (miss_inc == MISS_W'(MAX_MISS)) begin
                                state_q <= StSearch;
                                locked  <= 1'b0;
                                good_q  <= '0;
                            end
                            miss_q <= miss_inc;
                        end
                    end
                    default: state_q <= StSearch;
                endcase

                since_q <= x_nxt;
                if (line_start) begin
                    h_sync_pulse <= 1'b1;
                    if (vflag_q) begin
                        v_sync_pulse <= 1'b1;
                        y_coord      <= '0;
                        field        <= field_n_q;
                        vflag_q      <= 1'b0;
                    end else if (y_coord != '1) begin
                        y_coord <= y_coord + 1'b1;
                    end
                    if (real_start) begin
                        line_len <= (since_q == '1) ? since_q : since_q + 1'b1;
                    end
                end
                // Placed after the line-start block so a broad pulse ending on a start arms the next one.
                if (broad_edge && !vflag_q) begin
                    vflag_q   <= 1'b1;
                    field_n_q <= in_half;
                end

                // Lock state and y only change on line starts, where x_nxt is 0, so current values suffice.
                active_video <= (state_q == StLocked) && !sync_nxt
                                && (y_coord >= CNT_W'(V_ACTIVE))
                                && (x_nxt > ACT_LO) && (x_nxt <= ACT_HI);
            end
        end
    end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder: lock-up, equaliser/broad pulses, noise, freeze, reset,
// and flywheel coasting until lock loss.
module tb_video_sync_decoder;

    localparam logic [11:0] BLANK = 12'd1000;
    localparam logic [11:0] TIP   = 12'd200;
    localparam logic [11:0] DIP   = 12'd300;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [11:0] adc_data;
    logic        h_sync_pulse, v_sync_pulse, field, active_video, locked;
    logic [11:0] x_coord, y_coord, line_len;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    video_sync_decoder #(.V_ACTIVE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .h_sync_pulse (h_sync_pulse),
        .v_sync_pulse (v_sync_pulse),
        .field        (field),
        .active_video (active_video),
        .x_coord      (x_coord),
        .y_coord      (y_coord),
        .locked       (locked),
        .line_len     (line_len)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] d);
        adc_data     = d;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic [11:0] d, input int n);
        for (int i = 0; i < n; i++) send(d);
    endtask

    // Line begins with the blank sample that ends the previous tip.
    task automatic line();
        seg(BLANK, 2283);
        seg(TIP, 60);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h"}, h_sync_pulse, 0);
        check({tag, "_v"}, v_sync_pulse, 0);
        check({tag, "_field"}, field, 0);
        check({tag, "_active"}, active_video, 0);
        check({tag, "_x"}, x_coord, 0);
        check({tag, "_y"}, y_coord, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_line_len"}, line_len, 0);
        check({tag, "_tip"}, dut.tip_q, 4095);
    endtask

    task automatic acquire_lock();
        seg(TIP, 60);
        send(BLANK);
        check("first_edge_h", h_sync_pulse, 1);
        check("first_edge_len", line_len, 61);
        check("first_edge_locked", locked, 0);
        seg(BLANK, 2282);
        seg(TIP, 60);
        repeat (6) line();
        send(BLANK);
        seg(BLANK, 175);
        send(BLANK);
        check("prelock_x", x_coord, 176);
        check("prelock_active", active_video, 0);
        check("prelock_locked", locked, 0);
        seg(BLANK, 2106);
        seg(TIP, 60);
        send(BLANK);
        check("lock_locked", locked, 1);
        check("lock_h", h_sync_pulse, 1);
        check("lock_len", line_len, 2343);
        check("lock_x", x_coord, 0);
        check("lock_y", y_coord, 9);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        adc_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        acquire_lock();
        send(BLANK);
        check("strobe_width", h_sync_pulse, 0);
        check("x_after_start", x_coord, 1);
        seg(BLANK, 174);
        check("bp_edge_active", active_video, 0);
        send(BLANK);
        check("first_active_x", x_coord, 176);
        check("first_active", active_video, 1);
        seg(BLANK, 1918);
        send(BLANK);
        check("last_active_x", x_coord, 2095);
        check("last_active", active_video, 1);
        send(BLANK);
        check("after_active", active_video, 0);
        check("tip_level", dut.tip_q, 200);
        check("threshold", dut.thr, 450);
        seg(BLANK, 186);
        seg(TIP, 60);

        // Equaliser at half line.
        send(BLANK);
        check("eq_line_y", y_coord, 10);
        seg(BLANK, 1142);
        seg(TIP, 30);
        send(BLANK);
        check("eq_no_h", h_sync_pulse, 0);
        check("eq_x", x_coord, 1173);
        check("eq_y", y_coord, 10);
        seg(BLANK, 1109);
        seg(TIP, 60);

        // Broad pulse ending mid-line gives the even field.
        send(BLANK);
        seg(BLANK, 272);
        seg(TIP, 900);
        send(BLANK);
        check("broad1_no_v", v_sync_pulse, 0);
        check("broad1_field_hold", field, 0);
        seg(BLANK, 1109);
        seg(TIP, 60);
        send(BLANK);
        check("vs1_v", v_sync_pulse, 1);
        check("vs1_h", h_sync_pulse, 1);
        check("vs1_field", field, 1);
        check("vs1_y", y_coord, 0);

        // Broad pulse straddling a coasted start, ending at since=300: odd field.
        seg(BLANK, 1808);
        seg(TIP, 599);
        send(TIP);
        check("broad2_coast_h", h_sync_pulse, 1);
        check("broad2_coast_x", x_coord, 0);
        check("broad2_coast_locked", locked, 1);
        check("broad2_coast_v", v_sync_pulse, 0);
        seg(TIP, 300);
        send(BLANK);
        check("broad2_end_h", h_sync_pulse, 0);
        seg(BLANK, 1981);
        seg(TIP, 60);
        send(BLANK);
        check("vs2_v", v_sync_pulse, 1);
        check("vs2_h", h_sync_pulse, 1);
        check("vs2_field", field, 0);
        check("vs2_y", y_coord, 0);
        check("vs2_len", line_len, 2343);

        // Noise: short dip, then hysteresis band hold in both sync states.
        seg(BLANK, 499);
        seg(DIP, 10);
        send(BLANK);
        check("glitch_h", h_sync_pulse, 0);
        check("glitch_x", x_coord, 510);
        seg(DIP, 5);
        for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 12'd450 : 12'd470);
        check("hyst_hold_high", dut.sync_lvl_q, 1);
        send(BLANK);
        check("hyst_exit_h", h_sync_pulse, 0);
        for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 12'd450 : 12'd470);
        check("hyst_hold_low", dut.sync_lvl_q, 0);
        check("noise_x", x_coord, 536);
        seg(BLANK, 1746);
        seg(TIP, 60);
        send(BLANK);
        check("post_noise_h", h_sync_pulse, 1);
        check("post_noise_y", y_coord, 1);

        // sample_valid low: strobe clears, everything else frozen.
        sample_valid = 1'b0;
        adc_data     = '0;
        @(posedge clk);
        #1;
        check("freeze_h_clear", h_sync_pulse, 0);
        repeat (99) @(posedge clk);
        #1;
        check("freeze_x", x_coord, 0);
        check("freeze_y", y_coord, 1);
        check("freeze_locked", locked, 1);
        check("freeze_tip", dut.tip_q, 200);
        send(BLANK);
        check("resume_x", x_coord, 1);
        seg(BLANK, 499);

        // Reset mid-line overrides a valid sample.
        rst          = 1'b1;
        sample_valid = 1'b1;
        adc_data     = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("midreset");

        // Relock, then drop hsync: three coasts keep lock, the fourth loses it.
        acquire_lock();
        for (int k = 1; k <= 4; k++) begin
            seg(BLANK, 2407);
            if (k == 1) begin
                check("coast_pre_x", x_coord, 2407);
                check("coast_pre_h", h_sync_pulse, 0);
            end
            send(BLANK);
            check($sformatf("coast%0d_h", k), h_sync_pulse, 1);
            check($sformatf("coast%0d_x", k), x_coord, 0);
            check($sformatf("coast%0d_locked", k), locked, (k < 4) ? 1 : 0);
        end
        check("coast_len_kept", line_len, 2343);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
